// File: rtl/ham_secded_decoder_pipe.sv
// ham_secded_decoder_pipe
//   Two-stage pipelined extended-Hamming SECDED decoder with valid/ready
//   handshakes on both sides. It corrects single-bit errors, including an
//   error in the overall parity bit, and flags double-bit errors.
//
//   Parameters:
//     R      number of Hamming parity bits (R >= 3)
//     CNT_W  error counter width (used only when HAM_ERR_CNT_EN is defined)
//     N      derived, 2**R-1: Hamming length without the overall parity bit
//     K      derived, N-R: number of data bits
//
//   Ports:
//     clk, rst_n            clock and synchronous active-low reset
//     in_valid / in_ready   input handshake
//     in_code[N:0]          [N-1:0] Hamming word (index j = position j+1),
//                           [N] overall parity
//     out_valid / out_ready output handshake
//     out_data[K-1:0]       corrected data (out_data[0] comes from index 2)
//     out_syn[R-1:0]        syndrome
//     out_sgl_err           single error corrected
//     out_dbl_err           uncorrectable double error
//
//   Optional macro HAM_ERR_CNT_EN adds these ports:
//     cnt_clr               clear both counters (wins over an increment)
//     corr_cnt              saturating count of single-error handshakes
//     uncorr_cnt            saturating count of double-error handshakes
module ham_secded_decoder_pipe #(
  parameter  int unsigned R     = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned N     = (1 << R) - 1,
  localparam int unsigned K     = N - R
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic [R-1:0] out_syn,
  output logic         out_sgl_err,
  output logic         out_dbl_err
`ifdef HAM_ERR_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);

  // Stage 1: raw word, syndrome and overall parity check
  logic         r_s1_valid;
  logic [N:0]   r_s1_code;
  logic [R-1:0] r_s1_syn;
  logic         r_s1_par;

  // Stage 2: registered outputs
  logic         r_s2_valid;
  logic [K-1:0] r_s2_data;
  logic [R-1:0] r_s2_syn;
  logic         r_s2_sgl;
  logic         r_s2_dbl;

  logic         w_s2_adv;
  logic [R-1:0] w_syn;
  logic         w_par;
  logic         w_corr;
  logic [N-1:0] w_fixed;
  logic [K-1:0] w_data;
  logic         w_sgl;
  logic         w_dbl;

  // Stage 2 can take new contents when empty or being drained this cycle;
  // stage 1 can then accept whenever it is empty or stage 2 can take it.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  always_comb begin
    w_syn = '0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned i = 0; i < R; i++) begin
        if ((((j + 1) >> i) & 1) != 0) begin
          w_syn[i] = w_syn[i] ^ in_code[j];
        end
      end
    end
  end

  assign w_par = ^in_code;

  // Overall parity odd means a single error; when the syndrome is zero that
  // error sits in the overall parity bit and the Hamming word is untouched.
  assign w_corr = r_s1_par && (r_s1_syn != '0);
  assign w_sgl  = r_s1_par;
  assign w_dbl  = !r_s1_par && (r_s1_syn != '0);

  always_comb begin
    w_fixed = '0;
    for (int unsigned j = 0; j < N; j++) begin
      w_fixed[j] = r_s1_code[j] ^ (w_corr && (r_s1_syn == R'(j + 1)));
    end
  end

  // Data bits are every position that is not a power of two, in order.
  always_comb begin
    int unsigned k;
    k      = 0;
    w_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (((j + 1) & j) != 0) begin
        w_data[k] = w_fixed[j];
        k         = k + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_syn   <= '0;
      r_s2_sgl   <= 1'b0;
      r_s2_dbl   <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        r_s1_code  <= in_code;
        r_s1_syn   <= w_syn;
        r_s1_par   <= w_par;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_data  <= w_data;
        r_s2_syn   <= r_s1_syn;
        r_s2_sgl   <= w_sgl;
        r_s2_dbl   <= w_dbl;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_data    = r_s2_data;
  assign out_syn     = r_s2_syn;
  assign out_sgl_err = r_s2_sgl;
  assign out_dbl_err = r_s2_dbl;

`ifdef HAM_ERR_CNT_EN
  logic             w_out_hs;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  assign w_out_hs = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_out_hs && r_s2_sgl && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (w_out_hs && r_s2_dbl && (r_uncorr_cnt != '1)) begin
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`endif

endmodule

// File: tb/tb_ham_secded_decoder_pipe.sv
// Testbench for ham_secded_decoder_pipe (R=4, CNT_W=2 for the optional
// counters). A behavioural decoder model feeds a scoreboard that is checked
// on every output handshake; directed vectors pin literal expectations.
module tb_ham_secded_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [3:0]  out_syn;
  logic        out_sgl_err;
  logic        out_dbl_err;
  logic        cnt_clr;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;

  always #5 clk = ~clk;

  ham_secded_decoder_pipe #(.R(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_syn     (out_syn),
    .out_sgl_err (out_sgl_err),
    .out_dbl_err (out_dbl_err)
`ifdef HAM_ERR_CNT_EN
    ,
    .cnt_clr     (cnt_clr),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt)
`endif
  );

`ifndef HAM_ERR_CNT_EN
  assign corr_cnt   = '0;
  assign uncorr_cnt = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: syndrome is the XOR of the positions of all set bits, the overall
  // check is the parity of the popcount. Result {data, syn, sgl, dbl}.
  function automatic logic [16:0] model(input logic [15:0] c);
    int unsigned syn;
    int unsigned k;
    logic        odd;
    logic [14:0] w;
    logic [10:0] d;
    logic [3:0]  s4;
    syn = 0;
    k   = 0;
    d   = '0;
    w   = c[14:0];
    for (int unsigned p = 1; p <= 15; p++) if (c[p-1]) syn = syn ^ p;
    odd = ($countones(c) % 2) == 1;
    if (odd && syn != 0) w[syn-1] = ~w[syn-1];
    for (int unsigned p = 1; p <= 15; p++) begin
      if ($countones(p) != 1) begin
        d[k] = w[p-1];
        k++;
      end
    end
    s4 = syn[3:0];
    return {d, s4, odd, (syn != 0) && !odd};
  endfunction

  // Scoreboard / compare process, sampled on the falling edge.
  logic [16:0] exp_q[$];
  logic [16:0] exp_e;
  logic [16:0] prev_o;
  bit          have_prev = 0;
  int unsigned m_corr = 0;
  int unsigned m_uncorr = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 0;
      m_corr    = 0;
      m_uncorr  = 0;
    end else begin
`ifdef HAM_ERR_CNT_EN
      chk("corr_cnt_model", corr_cnt, m_corr);
      chk("uncorr_cnt_model", uncorr_cnt, m_uncorr);
`endif
      if (have_prev) begin
        chk("held_valid", out_valid, 1);
        chk("held_outputs", {out_data, out_syn, out_sgl_err, out_dbl_err}, prev_o);
      end
      have_prev = 0;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
          exp_e = '0;
        end else begin
          exp_e = exp_q.pop_front();
          chk("model_outputs", {out_data, out_syn, out_sgl_err, out_dbl_err}, exp_e);
        end
        if (cnt_clr) begin
          m_corr   = 0;
          m_uncorr = 0;
        end else begin
          if (exp_e[1] && m_corr < 3) m_corr++;
          if (exp_e[0] && m_uncorr < 3) m_uncorr++;
        end
      end else begin
        if (cnt_clr) begin
          m_corr   = 0;
          m_uncorr = 0;
        end
        if (out_valid) begin
          have_prev = 1;
          prev_o    = {out_data, out_syn, out_sgl_err, out_dbl_err};
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_code));
    end
  end

  // One word through an idle pipeline with out_ready=1; checks latency and
  // literal outputs, optionally pulsing cnt_clr on the output handshake.
  task automatic send_one(input logic [15:0] c, input logic [10:0] ed, input logic [3:0] es,
                          input logic esgl, input logic edbl, input logic clr);
    int n;
    bit seen;
    chk("in_ready_idle", in_ready, 1);
    in_code  = c;
    in_valid = 1'b1;
    n        = 0;
    seen     = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
      if (out_valid) seen = 1;
    end
    chk("latency", n, 2);
    chk("out_data", out_data, ed);
    chk("out_syn", out_syn, es);
    chk("out_sgl", out_sgl_err, esgl);
    chk("out_dbl", out_dbl_err, edbl);
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  // Hold in_valid with a word until it is accepted (bounded).
  task automatic push_word(input logic [15:0] c);
    bit hs;
    hs       = 0;
    in_code  = c;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
    end
    if (!hs) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && (exp_q.size() != 0 || out_valid); t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic [15:0] bp_words[6] = '{16'hFFFF, 16'h0000, 16'hFFFB, 16'h0010, 16'h8000, 16'h0003};
  int unsigned out_before;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_syn", out_syn, 0);
    chk("reset_flags", {out_sgl_err, out_dbl_err}, 0);
    rst_n = 1'b1;
    chk("ready_after_reset", in_ready, 1);

    // Directed vectors
    send_one(16'h0000, 11'h000, 4'h0, 0, 0, 0);
    send_one(16'hFFFF, 11'h7FF, 4'h0, 0, 0, 0);
    send_one(16'hFFFB, 11'h7FF, 4'h3, 1, 0, 0);
    send_one(16'h0010, 11'h000, 4'h5, 1, 0, 0);
    send_one(16'h8000, 11'h000, 4'h0, 1, 0, 0);
    send_one(16'h0003, 11'h000, 4'h3, 0, 1, 0);
    send_one(16'h0020, 11'h000, 4'h6, 1, 0, 0);

    // Backpressure: 6 words streamed while out_ready is low for 5 cycles
    out_before = n_out;
    out_ready  = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push_word(bp_words[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data_first", out_data, 11'h7FF);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_word_count", n_out - out_before, 6);

    // Reset with two words in flight
    out_ready = 1'b0;
    push_word(16'hFFFB);
    push_word(16'h0010);
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
`ifdef HAM_ERR_CNT_EN
    chk("midreset_corr_cnt", corr_cnt, 0);
    chk("midreset_uncorr_cnt", uncorr_cnt, 0);
`endif
    out_ready  = 1'b1;
    out_before = n_out;
    repeat (4) begin
      @(posedge clk); #1;
      chk("flushed_no_output", out_valid, 0);
    end
    chk("flushed_count", n_out - out_before, 0);

`ifdef HAM_ERR_CNT_EN
    // Saturating counters and clear priority
    repeat (5) send_one(16'h0010, 11'h000, 4'h5, 1, 0, 0);
    chk("corr_cnt_saturated", corr_cnt, 2'd3);
    send_one(16'h0003, 11'h000, 4'h3, 0, 1, 0);
    chk("uncorr_cnt_one", uncorr_cnt, 2'd1);
    send_one(16'h0003, 11'h000, 4'h3, 0, 1, 1);
    chk("uncorr_cnt_cleared", uncorr_cnt, 2'd0);
    chk("corr_cnt_cleared", corr_cnt, 2'd0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ham_secded_decoder_pipe.md
Name: ham_secded_decoder_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder; successor to the fixed (15,11) single-error-correct decoder.
- Accepts an extended Hamming codeword with a valid/ready handshake and corrects single-bit errors.
- Detects and flags double-bit errors, then returns data, syndrome and status with a valid/ready handshake.
- Sits between a memory or channel read port and the consumer; sustains one word per cycle with full backpressure.

Parameters:
- R, 4, number of Hamming parity bits (R >= 3).
- N, 2**R-1, derived localparam: Hamming code length excluding the overall parity bit.
- K, N-R, derived localparam: number of data bits.
- CNT_W, 16, width of the error counters (only used with HAM_ERR_CNT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept the word this cycle.
- in_code  in  N+1  bits [N-1:0] are the Hamming word; bit N is overall parity.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  K  corrected data.
- out_syn  out  R  syndrome of the word.
- out_sgl_err  out  1  single error detected and corrected.
- out_dbl_err  out  1  uncorrectable double error detected.
- cnt_clr  in  1  clear the counters (HAM_ERR_CNT_EN only).
- corr_cnt  out  CNT_W  count of corrected words (HAM_ERR_CNT_EN only).
- uncorr_cnt  out  CNT_W  count of double-error words (HAM_ERR_CNT_EN only).

Behaviour:
- Bit layout: in_code[j] has Hamming position j+1.
  - Parity bits sit at indices 2^i-1.
  - Data bits occupy the remaining indices below N in ascending order; out_data[0] comes from index 2.
- Syndrome bit s[i] is the XOR of in_code[j] for all j < N where bit i of (j+1) is 1. Overall check o is the XOR of in_code[N:0].
- Decode rules:
  - s=0, o=0: clean; both flags 0.
  - s!=0, o=1: flip bit s-1, then extract data; out_sgl_err=1.
  - s=0, o=1: the error is in the overall parity bit; data is unchanged; out_sgl_err=1.
  - s!=0, o=0: data is extracted uncorrected; out_dbl_err=1.
- The two flags are never both 1.
- Pipeline:
  - Stage 1 registers the word, s and o.
  - Stage 2 registers the corrected data, syndrome and flags, which drive the outputs.
  - With out_ready held at 1, latency is 2 cycles from the in_valid&&in_ready edge to out_valid. Throughput is 1 word per cycle.
- Handshake:
  - A stage advances when it is empty or its contents are consumed in the same cycle.
  - in_ready = !s1_valid || stage-1-advancing. It depends combinationally on out_ready; there is no combinational path from in_valid.
  - Outputs stay stable while out_valid=1 && out_ready=0.
  - No word is dropped or duplicated.
- Reset: while rst_n=0 at a clock edge, all valid bits, out_data, out_syn, both flags and both counters become 0.
  - In-flight words are discarded.
  - in_ready is 1 in the first cycle after reset is released.

Optional Feature:
- Macro: HAM_ERR_CNT_EN.
- When defined:
  - corr_cnt increments on each output handshake with out_sgl_err=1.
  - uncorr_cnt increments on each output handshake with out_dbl_err=1.
  - Both counters saturate at all-ones.
  - cnt_clr=1 zeroes both counters and takes priority over a same-cycle increment.
- When undefined: cnt_clr, corr_cnt and uncorr_cnt ports and their logic are absent; all decode behaviour is identical.

Test Plan:
- R=4, out_ready=1.
  - in_code=16'h0000 -> out_data=11'h000, syn=0, both flags 0, 2 cycles later.
  - in_code=16'hFFFF -> out_data=11'h7FF, clean.
- Single errors:
  - in_code=16'hFFFB -> syn=4'h3, out_data=11'h7FF, sgl=1.
  - in_code=16'h0010 -> syn=4'h5, out_data=11'h000, sgl=1.
  - in_code=16'h8000 -> syn=0, out_data=11'h000, sgl=1.
- Double error: in_code=16'h0003 -> syn=4'h3, dbl=1, sgl=0, out_data=11'h000.
- Backpressure:
  - Stream 6 words; hold out_ready=0 for 5 cycles.
  - After 2 words are accepted, in_ready=0 and out_data is stable.
  - Then all 6 words emerge in order with no loss.
- Reset mid-operation: rst_n=0 for 1 cycle with 2 words in flight -> out_valid=0 and counters=0 next cycle; the old words never appear.
- Counters (HAM_ERR_CNT_EN, CNT_W=2):
  - 5 single-error words -> corr_cnt=3 (saturated).
  - cnt_clr coincident with a double-error handshake -> uncorr_cnt=0.
